// File: rtl/channel_fifo_stage.sv
// Purpose : valid/ready FIFO buffering words between the input channel shifter and the memory controller.
// Latency : a word written into an empty FIFO is visible on out_data/out_valid one cycle after its write edge.
// Backpressure: in_ready is low only while full, and comes from registered state only. out_ready never reaches in_ready.
//
// Optional feature macro: STAGE_DROP_CNT_EN adds a saturating 16-bit refused-write counter (drop_count).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_data/in_valid    write side; in_ready = !full
//   out_data/out_valid  head word (0 when empty) shown first-word-fall-through; out_valid = !empty
//   out_ready           consumer accepts the head word
//   count, full, empty  occupancy (0..DEPTH) and registered flags
//   drop_count          refused-write counter (STAGE_DROP_CNT_EN only)

module channel_fifo_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
`ifdef STAGE_DROP_CNT_EN
  output logic             full,
  output logic             empty,
  output logic [15:0]      drop_count
`else
  output logic             full,
  output logic             empty
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic             full_q;
  logic             empty_q;
  logic             push;
  logic             pop;

  assign in_ready  = !full_q;
  assign out_valid = !empty_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign out_data = empty_q ? '0 : mem[rd_ptr];

  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Storage has no reset; out_data is masked to 0 while empty instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Flags are registered from the next count so in_ready/out_valid have no
  // combinational path from the opposite side of the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

`ifdef STAGE_DROP_CNT_EN
  logic [15:0] drop_q;

  assign drop_count = drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (in_valid && !in_ready && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end
`endif

endmodule
